// File: rtl/deint_sched_pkg.sv
// Shared definitions for the deinterleaver symbol scheduler.
// State encoding, carriers per symbol and per-rate output strobe counts.
// No logic; imported by deint_sched and deint_sched_cnt.
package deint_sched_pkg;

  // Scheduler state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // Data carriers per OFDM symbol
  localparam logic [5:0] N_SD_LEGACY = 6'd48;
  localparam logic [5:0] N_SD_HT     = 6'd52;

  // Deinterleaver output strobes per symbol. The deinterleaver emits two
  // coded bits per strobe, so this is N_CBPS/2. Reserved bits [6:4] set,
  // legacy codes 0-7 and HT MCS above 7 are unknown and return 0.
  function automatic logic [7:0] OUT_PER_SYM(input logic [7:0] rate);
    logic [7:0] n;
    n = 8'd0;
    if (rate[6:4] == 3'b000) begin
      if (rate[7]) begin
        case (rate[3:0])
          4'd0:             n = 8'd26;
          4'd1, 4'd2:       n = 8'd52;
          4'd3, 4'd4:       n = 8'd104;
          4'd5, 4'd6, 4'd7: n = 8'd156;
          default:          n = 8'd0;
        endcase
      end else begin
        case (rate[3:0])
          4'hB, 4'hF: n = 8'd24;
          4'hA, 4'hE: n = 8'd48;
          4'h9, 4'hD: n = 8'd96;
          4'h8, 4'hC: n = 8'd144;
          default:    n = 8'd0;
        endcase
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/deint_sched_cnt.sv
// Compare counter: counts inc pulses, flags the pulse that reaches target.
// Latency: hit is combinational with inc; count self-clears on hit.
// Backpressure: none; clr has priority over inc and suppresses hit.
module deint_sched_cnt
  import deint_sched_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] target,
  output logic         hit
);

  logic [W-1:0] count;
  logic [W-1:0] count_inc;

  assign count_inc = count + W'(1);
  // A target of 0 never hits because count_inc is never 0 before wrap.
  assign hit = inc & ~clr & (count_inc == target);

  // Count up, restart on clear or when the target is reached
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr || hit) begin
      count <= '0;
    end else if (inc) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/deint_sched.sv
// Symbol scheduler between demapper and deinterleaver (optional stats: DEINT_SCHED_STATS_EN).
// Latency: sym_done/pkt_done registered, one cycle after the final out strobe.
// Backpressure: up_ready only in FILL; strobes while not ready are dropped and flagged.
module deint_sched
  import deint_sched_pkg::*;
#(
  parameter int NSYM_W        = 16,
  parameter int DRAIN_TIMEOUT = 512,
  parameter int GAP_CYCLES    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        rate,
  input  logic [NSYM_W-1:0] num_sym,
  input  logic              up_strobe,
  output logic              up_ready,
  output logic              deint_in_strobe,
  input  logic              deint_out_strobe,
  output logic              deint_enable,
  output logic              deint_reset,
  output logic [7:0]        deint_rate,
  output logic              sym_done,
  output logic [NSYM_W-1:0] sym_cnt,
  output logic              pkt_done,
  output logic              busy,
  output logic              overrun,
`ifdef DEINT_SCHED_STATS_EN
  output logic              timeout,
  output logic [15:0]       stat_drops,
  output logic [15:0]       stat_pkts
`else
  output logic              timeout
`endif
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_TARGET = TMO_W'(DRAIN_TIMEOUT);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [7:0]        rate_q;
  logic [NSYM_W-1:0] num_sym_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic              init_gap;

  logic [5:0]        n_sd;
  logic [7:0]        out_per_sym;
  logic              car_hit;
  logic              out_hit;
  logic              idle_hit;

  logic              abort_ev;
  logic              start_ev;
  logic              start_pkt;
  logic              start_empty;
  logic              sym_ev;
  logic              last_sym;
  logic              tmo_ev;
  logic              bad_rate;
  logic              drop;

  assign n_sd        = rate_q[7] ? N_SD_HT : N_SD_LEGACY;
  assign out_per_sym = OUT_PER_SYM(rate_q);

  assign up_ready        = (state == ST_FILL);
  assign deint_in_strobe = up_strobe & up_ready;
  assign deint_enable    = (state == ST_FILL) || (state == ST_DRAIN);
  assign deint_reset     = (state == ST_GAP);
  assign deint_rate      = rate_q;
  // The power-on gap is housekeeping, not a packet, so it does not count as busy.
  assign busy            = (state != ST_IDLE) && !init_gap;

  // Abort overrides every other event in the same cycle.
  assign abort_ev    = abort && (state != ST_IDLE);
  assign start_ev    = start && (state == ST_IDLE);
  assign start_pkt   = start_ev && (num_sym != '0);
  assign start_empty = start_ev && (num_sym == '0);
  assign sym_ev      = !abort_ev && (state == ST_DRAIN) && out_hit;
  assign last_sym    = sym_ev && ((sym_cnt + NSYM_W'(1)) == num_sym_q);
  assign tmo_ev      = !abort_ev && (state == ST_DRAIN) && idle_hit;
  // An unknown rate would drain forever; treat it as an immediate timeout.
  assign bad_rate    = !abort_ev && (state == ST_FILL) && car_hit && (out_per_sym == 8'd0);
  assign drop        = up_strobe && !up_ready;

  // Carriers accepted in the current symbol
  deint_sched_cnt #(.W(6)) u_car_cnt (
    .clock  (clock),
    .reset  (reset),
    .clr    ((state != ST_FILL) || abort_ev),
    .inc    (deint_in_strobe),
    .target (n_sd),
    .hit    (car_hit)
  );

  // Deinterleaver output strobes in the current symbol; ignored outside DRAIN
  deint_sched_cnt #(.W(8)) u_out_cnt (
    .clock  (clock),
    .reset  (reset),
    .clr    ((state != ST_DRAIN) || abort_ev),
    .inc    ((state == ST_DRAIN) && deint_out_strobe),
    .target (out_per_sym),
    .hit    (out_hit)
  );

  // Consecutive DRAIN cycles without an output strobe
  deint_sched_cnt #(.W(TMO_W)) u_idle_cnt (
    .clock  (clock),
    .reset  (reset),
    .clr    ((state != ST_DRAIN) || deint_out_strobe || abort_ev),
    .inc    ((state == ST_DRAIN) && !deint_out_strobe),
    .target (TMO_TARGET),
    .hit    (idle_hit)
  );

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_pkt) state_nxt = ST_FILL;
      ST_FILL:  if (car_hit) state_nxt = bad_rate ? ST_GAP : ST_DRAIN;
      ST_DRAIN: begin
        if (sym_ev)      state_nxt = last_sym ? ST_GAP : ST_FILL;
        else if (tmo_ev) state_nxt = ST_GAP;
      end
      ST_GAP:   if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_GAP;
    endcase
    if (abort_ev) state_nxt = ST_GAP;
  end

  // State register and gap timer; an abort inside GAP restarts the gap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_GAP;
      gap_cnt  <= '0;
      init_gap <= 1'b1;
    end else begin
      state <= state_nxt;
      if ((state != ST_GAP) || (state_nxt != ST_GAP) || abort_ev) gap_cnt <= '0;
      else                                                       gap_cnt <= gap_cnt + GAP_W'(1);
      if (state == ST_IDLE) init_gap <= 1'b0;
    end
  end

  // Packet parameters latched on start, held until the next accepted start
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rate_q    <= 8'd0;
      num_sym_q <= '0;
    end else if (start_pkt) begin
      rate_q    <= rate;
      num_sym_q <= num_sym;
    end
  end

  // Completion pulses, symbol count and sticky error flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sym_done <= 1'b0;
      pkt_done <= 1'b0;
      sym_cnt  <= '0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      sym_done <= sym_ev;
      pkt_done <= last_sym || start_empty;
      if (start_pkt)   sym_cnt <= '0;
      else if (sym_ev) sym_cnt <= sym_cnt + NSYM_W'(1);
      if (start_pkt) overrun <= 1'b0;
      else if (drop && ((state == ST_FILL) || (state == ST_DRAIN))) overrun <= 1'b1;
      if (start_pkt) timeout <= 1'b0;
      else if (tmo_ev || bad_rate) timeout <= 1'b1;
    end
  end

`ifdef DEINT_SCHED_STATS_EN
  // Drop and packet statistics, cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_drops <= 16'd0;
      stat_pkts  <= 16'd0;
    end else begin
      if (drop && (stat_drops != 16'hFFFF)) stat_drops <= stat_drops + 16'd1;
      if (last_sym || start_empty)          stat_pkts  <= stat_pkts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_deint_sched.sv
// Directed bench for deint_sched with a completion-pulse scoreboard.
// Stimulus pushes expected sym_done/pkt_done events; a negedge monitor pops them.
// Level checks (ready, reset, flags) are made inline by the stimulus.
module tb_deint_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  rate = 8'd0;
  logic [15:0] num_sym = 16'd0;
  logic        up_strobe = 1'b0;
  logic        up_ready;
  logic        deint_in_strobe;
  logic        deint_out_strobe = 1'b0;
  logic        deint_enable;
  logic        deint_reset;
  logic [7:0]  deint_rate;
  logic        sym_done;
  logic [15:0] sym_cnt;
  logic        pkt_done;
  logic        busy;
  logic        overrun;
  logic        timeout;
`ifdef DEINT_SCHED_STATS_EN
  logic [15:0] stat_drops;
  logic [15:0] stat_pkts;
  logic [15:0] drops0;
`endif

  typedef struct packed {
    logic        sd;
    logic        pd;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  logic blocked = 1'b0;

  always #5 clock = ~clock;

  deint_sched dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .rate             (rate),
    .num_sym          (num_sym),
    .up_strobe        (up_strobe),
    .up_ready         (up_ready),
    .deint_in_strobe  (deint_in_strobe),
    .deint_out_strobe (deint_out_strobe),
    .deint_enable     (deint_enable),
    .deint_reset      (deint_reset),
    .deint_rate       (deint_rate),
    .sym_done         (sym_done),
    .sym_cnt          (sym_cnt),
    .pkt_done         (pkt_done),
    .busy             (busy),
    .overrun          (overrun),
`ifdef DEINT_SCHED_STATS_EN
    .timeout          (timeout),
    .stat_drops       (stat_drops),
    .stat_pkts        (stat_pkts)
`else
    .timeout          (timeout)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic sd, input logic pd, input logic [15:0] cnt);
    exp_t e;
    e.sd  = sd;
    e.pd  = pd;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic start_pkt(input logic [7:0] r, input logic [15:0] n);
    rate    = r;
    num_sym = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic feed(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      up_strobe = 1'b1;
      if (i == n - 1) chk({nm, "_ready_last"}, 32'(up_ready), 32'd1);
      tick();
    end
    up_strobe = 1'b0;
    chk({nm, "_ready_drop"}, 32'(up_ready), 32'd0);
  endtask

  task automatic drain(input int n, input logic push, input logic pd, input logic [15:0] cnt);
    for (int i = 0; i < n; i++) begin
      deint_out_strobe = 1'b1;
      if (push && (i == n - 1)) push_exp(1'b1, pd, cnt);
      tick();
    end
    deint_out_strobe = 1'b0;
  endtask

  task automatic gap_to_idle(input string nm);
    chk({nm, "_gap_rst0"}, 32'(deint_reset), 32'd1);
    tick();
    chk({nm, "_gap_rst1"}, 32'(deint_reset), 32'd1);
    tick();
    chk({nm, "_idle_rst"}, 32'(deint_reset), 32'd0);
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  // Monitor: every completion pulse must match the next scoreboard entry
  always @(negedge clock) begin
    if (sym_done || pkt_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: sym_done=%0b pkt_done=%0b sym_cnt=%0d, no event expected",
                 sym_done, pkt_done, sym_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_sym_done", 32'(sym_done), 32'(mon_e.sd));
        chk("mon_pkt_done", 32'(pkt_done), 32'(mon_e.pd));
        chk("mon_sym_cnt", 32'(sym_cnt), 32'(mon_e.cnt));
      end
    end
    if (blocked && up_strobe) chk("in_strobe_blocked", 32'(deint_in_strobe), 32'd0);
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    // Reset
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_deint_reset", 32'(deint_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_up_ready", 32'(up_ready), 32'd0);
    chk("rst_enable", 32'(deint_enable), 32'd0);
    chk("rst_rate", 32'(deint_rate), 32'd0);
    chk("rst_sym_cnt", 32'(sym_cnt), 32'd0);
    reset = 1'b1;
    tick();
    chk("post_rst_reset1", 32'(deint_reset), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    tick();
    chk("post_rst_reset_low", 32'(deint_reset), 32'd0);
    chk("idle_up_ready", 32'(up_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Empty packet: pkt_done only, stays IDLE
    push_exp(1'b0, 1'b1, 16'd0);
    start_pkt(8'h0B, 16'd0);
    chk("empty_busy", 32'(busy), 32'd0);
    tick();

    // Abort in IDLE is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_rst", 32'(deint_reset), 32'd0);

    // Single legacy BPSK symbol
    start_pkt(8'h0B, 16'd1);
    chk("leg_busy", 32'(busy), 32'd1);
    chk("leg_enable", 32'(deint_enable), 32'd1);
    chk("leg_rate", 32'(deint_rate), 32'h0B);
    feed(48, "leg");
    chk("leg_drain_enable", 32'(deint_enable), 32'd1);
    drain(24, 1'b1, 1'b1, 16'd1);
    gap_to_idle("leg");

    // HT MCS0, three symbols
    start_pkt(8'h80, 16'd3);
    for (int s = 1; s <= 3; s++) begin
      feed(52, "ht");
      chk("ht_rate_stable", 32'(deint_rate), 32'h80);
      drain(26, 1'b1, (s == 3), 16'(s));
      if (s < 3) chk("ht_ready_back", 32'(up_ready), 32'd1);
    end
    gap_to_idle("ht");

    // Overrun during DRAIN
    start_pkt(8'h0B, 16'd1);
    feed(48, "ovr");
`ifdef DEINT_SCHED_STATS_EN
    drops0 = stat_drops;
`endif
    blocked = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_strobe = 1'b1;
      tick();
    end
    up_strobe = 1'b0;
    blocked = 1'b0;
    chk("ovr_flag", 32'(overrun), 32'd1);
`ifdef DEINT_SCHED_STATS_EN
    chk("ovr_stat_drops", 32'(stat_drops - drops0), 32'd4);
`endif
    drain(24, 1'b1, 1'b1, 16'd1);
    gap_to_idle("ovr");

    // Abort mid-FILL, start during GAP ignored, then a clean restart
    start_pkt(8'h0B, 16'd1);
    for (int i = 0; i < 20; i++) begin
      up_strobe = 1'b1;
      tick();
    end
    up_strobe = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_gap_rst", 32'(deint_reset), 32'd1);
    chk("abt_gap_enable", 32'(deint_enable), 32'd0);
    chk("abt_gap_busy", 32'(busy), 32'd1);
    start_pkt(8'h0A, 16'd1);
    chk("abt_start_ignored_rate", 32'(deint_rate), 32'h0B);
    chk("abt_start_ignored_rst", 32'(deint_reset), 32'd1);
    tick();
    chk("abt_idle_busy", 32'(busy), 32'd0);
    start_pkt(8'h0B, 16'd1);
    chk("abt_restart_sym_cnt", 32'(sym_cnt), 32'd0);
    chk("abt_restart_overrun", 32'(overrun), 32'd0);
    feed(48, "abt");
    drain(24, 1'b1, 1'b1, 16'd1);
    gap_to_idle("abt");

    // Drain timeout: 10 of 48 strobes, then silence
    start_pkt(8'h0A, 16'd2);
    feed(48, "tmo");
    drain(10, 1'b0, 1'b0, 16'd0);
    k = 0;
    while ((timeout !== 1'b1) && (k < 600)) begin
      tick();
      k++;
    end
    chk("tmo_cycles", 32'(k), 32'd512);
    chk("tmo_sym_cnt", 32'(sym_cnt), 32'd0);
    gap_to_idle("tmo");

    // Unknown rate code: timeout at the end of FILL
    start_pkt(8'h03, 16'd1);
    chk("unk_timeout_cleared", 32'(timeout), 32'd0);
    feed(48, "unk");
    chk("unk_timeout", 32'(timeout), 32'd1);
    gap_to_idle("unk");

    repeat (4) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
